// File: rtl/con_window.sv
// Purpose: 7x7 sliding-window generator feeding the convolution MAC; optional CON_WIN_SOF_EN adds a start-of-frame input.
// Latency: one cycle from an accepted pixel to the updated ima/enable/last.
// Backpressure: none; every pixel_valid beat is accepted, and idle beats freeze all state.
module con_window #(
    parameter int IMA = 8,
    parameter int K   = 7,
    parameter int COL = 28,
    parameter int ROW = 28
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IMA-1:0]       pix,
    input  logic                 pix_valid,
`ifdef CON_WIN_SOF_EN
    input  logic                 sof,
`endif
    output logic [IMA*K*K-1:0]   ima,
    output logic                 enable,
    output logic                 last
);

    localparam int CW = (COL > 1) ? $clog2(COL) : 1;
    localparam int RW = (ROW > 1) ? $clog2(ROW) : 1;
    localparam logic [CW-1:0] COL_MAX = CW'(COL - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(ROW - 1);
    localparam logic [CW-1:0] COL_MIN = CW'(K - 1);
    localparam logic [RW-1:0] ROW_MIN = RW'(K - 1);

    logic [CW-1:0]  col_q, col_d, col_eff;
    logic [RW-1:0]  row_q, row_d, row_eff;
    logic [IMA-1:0] lb_q  [K-1][COL];
    logic [IMA-1:0] lb_rd [K-1];
    logic [IMA-1:0] win_q [K][K];
    logic [IMA-1:0] win_d [K][K];
    logic           en_q, en_d;
    logic           last_q, last_d;
    logic           sof_acc;

`ifdef CON_WIN_SOF_EN
    assign sof_acc = pix_valid & sof;
`else
    assign sof_acc = 1'b0;
`endif

    // A start-of-frame beat is processed exactly as pixel (0,0).
    assign col_eff = sof_acc ? '0 : col_q;
    assign row_eff = sof_acc ? '0 : row_q;

    always_comb begin
        for (int j = 0; j < K - 1; j++) begin
            lb_rd[j] = lb_q[j][col_eff];
        end
    end

    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        win_d  = win_q;
        en_d   = 1'b0;
        last_d = 1'b0;
        if (pix_valid) begin
            if (col_eff == COL_MAX) begin
                col_d = '0;
                row_d = (row_eff == ROW_MAX) ? '0 : row_eff + RW'(1);
            end else begin
                col_d = col_eff + CW'(1);
                row_d = row_eff;
            end
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
            end
            for (int r = 0; r < K - 1; r++) begin
                win_d[r][K-1] = lb_rd[r];
            end
            win_d[K-1][K-1] = pix;
            // Left columns of a low col_cnt belong to the previous row, so mask them.
            en_d   = (row_eff >= ROW_MIN) && (col_eff >= COL_MIN);
            last_d = (row_eff == ROW_MAX) && (col_eff == COL_MAX);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q  <= '0;
            row_q  <= '0;
            en_q   <= 1'b0;
            last_q <= 1'b0;
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            en_q   <= en_d;
            last_q <= last_d;
            win_q  <= win_d;
        end
    end

    // Row buffers carry no reset: stale contents are never exposed past the validity mask.
    always_ff @(posedge clk) begin
        if (pix_valid) begin
            for (int j = 0; j < K - 2; j++) begin
                lb_q[j][col_eff] <= lb_rd[j+1];
            end
            lb_q[K-2][col_eff] <= pix;
        end
    end

    always_comb begin
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                ima[(r*K+c)*IMA +: IMA] = win_q[r][c];
            end
        end
    end

    assign enable = en_q;
    assign last   = last_q;

endmodule

// File: tb/tb_con_window.sv
// Randomised scoreboard bench for con_window against a frame-buffer reference model.
module tb_con_window;
    localparam int IMA  = 8;
    localparam int K    = 7;
    localparam int COL  = 28;
    localparam int ROW  = 28;
    localparam int W    = IMA*K*K;
    localparam int NPIX = ROW*COL;
    localparam int WPF  = (ROW-K+1)*(COL-K+1);

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           pix_valid = 1'b0;
    logic           sof = 1'b0;
    logic [IMA-1:0] pix = '0;
    logic [W-1:0]   ima;
    logic           enable;
    logic           last;

    always #5 clk = ~clk;

    con_window #(.IMA(IMA), .K(K), .COL(COL), .ROW(ROW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pix       (pix),
        .pix_valid (pix_valid),
`ifdef CON_WIN_SOF_EN
        .sof       (sof),
`endif
        .ima       (ima),
        .enable    (enable),
        .last      (last)
    );

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic         l;
        logic [W-1:0] w;
    } exp_t;

    exp_t           win_exp_q[$];
    bit             en_exp_q[$];
    logic [IMA-1:0] img [ROW][COL];
    int             pos = 0;
    int             sent = 0;
    int             exp_wins = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: position from accepted-pixel count, window cut directly out of the stored frame.
    task automatic model_accept(input logic [IMA-1:0] p, input bit s);
        int   r, c;
        exp_t e;
        if (s) pos = 0;
        r = pos / COL;
        c = pos % COL;
        img[r][c] = p;
        if (r >= K-1 && c >= K-1) begin
            for (int i = 0; i < K; i++)
                for (int j = 0; j < K; j++)
                    e.w[(i*K+j)*IMA +: IMA] = img[r-K+1+i][c-K+1+j];
            e.l = (r == ROW-1) && (c == COL-1);
            win_exp_q.push_back(e);
            en_exp_q.push_back(1'b1);
            exp_wins++;
        end else begin
            en_exp_q.push_back(1'b0);
        end
        pos = (pos + 1) % NPIX;
        sent++;
    endtask

    task automatic drive(input bit v, input logic [IMA-1:0] p, input bit s);
        pix_valid = v;
        pix       = p;
        sof       = s;
        if (v) model_accept(p, s);
        @(posedge clk);
        #1;
    endtask

    // Monitor side
    logic         acc_last = 1'b0;
    int           acc_idx = 0;
    int           win_cnt = 0;
    int           last_cnt = 0;
    int           en_idx [4096];
    logic [W-1:0] prev_ima = '0;
    logic [W-1:0] first_ima = '0;
    bit           be;
    exp_t         got_e;

    always @(posedge clk) acc_last <= rst_n & pix_valid;

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_ima", ima, '0);
            check("rst_enable", W'(enable), '0);
            check("rst_last", W'(last), '0);
        end else if (acc_last) begin
            acc_idx++;
            if (en_exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL en_queue: got pixel with no expectation, required one queued");
            end else begin
                be = en_exp_q.pop_front();
                check("enable", W'(enable), W'(be));
            end
            if (enable) begin
                if (win_cnt < 4096) en_idx[win_cnt] = acc_idx - 1;
                if (win_cnt == 0) first_ima = ima;
                win_cnt++;
                if (last) last_cnt++;
                if (win_exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL win_queue: got enable with no window queued, required none");
                end else begin
                    got_e = win_exp_q.pop_front();
                    check("ima", ima, got_e.w);
                    check("last", W'(last), W'(got_e.l));
                end
            end else begin
                check("last_no_enable", W'(last), '0);
            end
        end else begin
            check("idle_enable_last", W'({enable, last}), '0);
            check("idle_ima_stable", ima, prev_ima);
        end
        prev_ima = ima;
    end

    int start_idx, w0, n;
    logic [W-1:0] tmp;

    initial begin
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Continuous ramp frame
        for (int k = 0; k < NPIX; k++) drive(1'b1, IMA'(k % 256), 1'b0);
        drive(1'b0, '0, 1'b0);
        drive(1'b0, '0, 1'b0);
        check("frameA_windows", W'(win_cnt), W'(WPF));
        check("frameA_first_idx", W'(en_idx[0]), W'(174));
        tmp = first_ima;
        check("frameA_slice0", W'(tmp[7:0]), '0);
        check("frameA_slice48", W'(tmp[48*IMA +: IMA]), W'(174));
        check("frameA_last_count", W'(last_cnt), W'(1));

        // Same frame with alternating idle cycles
        for (int k = 0; k < NPIX; k++) begin
            drive(1'b1, IMA'(k % 256), 1'b0);
            drive(1'b0, IMA'($urandom), 1'b0);
        end
        check("frameB_windows", W'(win_cnt), W'(2*WPF));
        check("frameB_last_count", W'(last_cnt), W'(2));

        // Two back-to-back random frames
        start_idx = sent;
        w0 = win_cnt;
        for (int k = 0; k < 2*NPIX; k++) drive(1'b1, IMA'($urandom), 1'b0);
        drive(1'b0, '0, 1'b0);
        check("frameCD_windows", W'(win_cnt - w0), W'(2*WPF));
        check("frameC_first_idx", W'(en_idx[w0]), W'(start_idx + 174));
        check("frameD_first_idx", W'(en_idx[w0 + WPF]), W'(start_idx + NPIX + 174));

        // Reset mid-frame, then a gappy random frame
        for (int k = 0; k < 100; k++) drive(1'b1, IMA'($urandom), 1'b0);
        drive(1'b0, '0, 1'b0);
        rst_n = 1'b0;
        pos = 0;
        repeat (3) drive(1'b0, IMA'($urandom), 1'b0);
        rst_n = 1'b1;
        start_idx = sent;
        w0 = win_cnt;
        n = 0;
        while (n < NPIX) begin
            if ($urandom_range(0, 3) != 0) begin
                drive(1'b1, IMA'($urandom), 1'b0);
                n++;
            end else begin
                drive(1'b0, IMA'($urandom), 1'b0);
            end
        end
        drive(1'b0, '0, 1'b0);
        check("frameR_windows", W'(win_cnt - w0), W'(WPF));
        check("frameR_first_idx", W'(en_idx[w0]), W'(start_idx + 174));

`ifdef CON_WIN_SOF_EN
        // Partial frame abandoned by a start-of-frame pulse
        for (int k = 0; k < 300; k++) drive(1'b1, IMA'($urandom), 1'b0);
        drive(1'b0, '0, 1'b1);
        start_idx = sent;
        w0 = win_cnt;
        drive(1'b1, IMA'($urandom), 1'b1);
        for (int k = 1; k < NPIX; k++) drive(1'b1, IMA'($urandom), 1'b0);
        drive(1'b0, '0, 1'b0);
        check("frameS_windows", W'(win_cnt - w0), W'(WPF));
        check("frameS_first_idx", W'(en_idx[w0]), W'(start_idx + 174));
`endif

        repeat (3) drive(1'b0, '0, 1'b0);
        check("queues_drained", W'(win_exp_q.size() + en_exp_q.size()), '0);
        check("total_windows", W'(win_cnt), W'(exp_wins));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/con_window.md
# con_window

Streaming 7x7 sliding-window generator that sits directly upstream of the 49-tap convolution MAC. It accepts one 8-bit image pixel per valid cycle in raster order and keeps K-1 row buffers plus a KxK window register. For every fully-populated (valid, unpadded) window position it presents all K*K pixels on a flat bus, together with a one-cycle `enable` pulse that drives the MAC's `ima`/`enable` inputs. The MAC has no stall input, so this block has no backpressure.

## Interface

Parameters:
- `IMA`, 8: pixel width.
- `K`, 7: window size. The output bus carries K*K pixels, which equals the MAC's NUM of 49.
- `COL`, 28: image width in pixels.
- `ROW`, 28: image height in pixels.

Ports:
- `clk` in, 1: single clock, rising edge.
- `rst_n` in, 1: asynchronous, active-low reset.
- `pix` in, IMA: input pixel, unsigned.
- `pix_valid` in, 1: `pix` is accepted at a rising edge when this is high.
- `sof` in, 1: start of frame, qualified by `pix_valid`. Present only with `CON_WIN_SOF_EN`.
- `ima` out, IMA*K*K: window pixels. Slice `[(r*K+c)*IMA +: IMA]` holds window row r (0 = top) and column c (0 = left).
- `enable` out, 1: one-cycle pulse; `ima` holds a valid window in the same cycle.
- `last` out, 1: high together with `enable` for the final window of a frame.

## Operation

- Counters:
  - `col_cnt` counts 0..COL-1 and `row_cnt` counts 0..ROW-1. Both advance only on an accepted pixel.
  - `col_cnt` wraps to 0 and increments `row_cnt`.
  - At (ROW-1, COL-1) both counters wrap to 0, which starts the next frame.
- Line buffers:
  - K-1 buffers, each COL entries deep, addressed by `col_cnt`.
  - On an accepted pixel, buffer j is read at `col_cnt` and rewritten with the value read from buffer j+1 (or with `pix` for j = K-2). The buffers therefore hold the previous K-1 rows.
- Window register:
  - On an accepted pixel, all columns shift left by one.
  - The new column K-1 is {buffer0, …, buffer K-2, `pix`} for rows 0..K-1.
- Window validity:
  - A window is valid when the accepting pixel has `row_cnt >= K-1` and `col_cnt >= K-1`.
  - Windows with `col_cnt < K-1` span a row boundary and are suppressed, as are all windows before row K-1. This includes stale rows left over from a previous frame.
- `last` is asserted when the accepting pixel is at (ROW-1, COL-1).
- Windows per frame: (ROW-K+1)*(COL-K+1), which is 484 with the defaults.
- No arithmetic is applied to pixel data; pixels are moved only.
- Idle cycles (`pix_valid` low) are allowed at any point:
  - Counters, buffers and the window register hold their values.
  - `enable` and `last` are 0.
  - `ima` holds its last value.

## Timing

- Reset values: `ima` = 0, `enable` = 0, `last` = 0, counters 0, window register 0. Line-buffer contents are don't-care, because validity masking hides them.
- Latency: for a pixel accepted at edge N, the updated `ima` and its `enable`/`last` are visible in the cycle after edge N (registered, 1 cycle). `enable` falls at edge N+1 unless pixel N+1 also completes a valid window.
- Sustained throughput: one window per clock while the input is continuous and inside the valid region.
- Reset asserted mid-frame: all state clears immediately. The next accepted pixel is treated as (0,0). No `enable` is produced until K-1 new rows plus K pixels have arrived.
- `ima` changes only on accepted pixels or on reset.

## Configuration

- `CON_WIN_SOF_EN` defined:
  - The `sof` port exists.
  - `pix_valid` && `sof` forces the accepted pixel to be treated as (0,0). Counters become (0,1) after that edge, discarding any partial frame, and no window is emitted for that pixel.
  - `sof` while `pix_valid` is low is ignored.
- `CON_WIN_SOF_EN` undefined:
  - No `sof` port.
  - Frame alignment comes only from reset and counter wrap.

## Test plan

- Continuous 28x28 frame, pixel(r,c) = (r*28+c) mod 256:
  - First `enable` follows pixel index 174, i.e. (6,6).
  - `ima` slice 0 = 0 and slice 48 = 174.
  - Exactly 484 `enable` pulses; only the last carries `last`=1, with slice 48 = 783 mod 256 = 15.
- Same frame with `pix_valid` toggled 1,0,1,0: identical sequence of 484 windows; `enable` never high in an idle cycle; `ima` stable across idle cycles.
- Two back-to-back frames:
  - The second frame's first `enable` follows its pixel (6,6), 784+175 accepted pixels from the start.
  - No window spans the frame boundary.
  - 968 pulses total.
- Assert `rst_n` low after 100 pixels, then stream a full frame: outputs read 0 during reset; the new frame produces 484 windows matching the first scenario.
- With `CON_WIN_SOF_EN`: after 300 pixels, drive `sof`=1 with `pix_valid`, then a full frame. Windows align to the new frame, with the first `enable` after its pixel 174.
- Row-boundary check: pixels at `col_cnt` 0..5 of rows ≥ 6 produce no `enable`; the pixel at `col_cnt` 6 does.
